// File: rtl/adc_capture_buf.sv
// ---------------------------------------------------------------------------
// adc_capture_buf
//   Trigger-based ADC capture buffer. While armed, samples are written into a
//   circular buffer. A trigger records where the trigger landed and starts a
//   post-trigger count. Once POST_CNT post samples are stored, the buffer
//   freezes until the next arm. Reads are registered and allowed in any state.
//
// Ports
//   clk         single clock, all state on rising edge
//   rst         asynchronous, active-high reset
//   wr_en/din   sample strobe and ADC sample
//   arm         start a capture (IDLE or DONE only)
//   trig        trigger event (ARMED only)
//   rd_en       read request for rd_addr; dout/dout_valid follow one cycle later
//   state       IDLE=0, ARMED=1, POST=2, DONE=3
//   trig_ptr    address of the first sample at or after the trigger
//   wrapped     write pointer wrapped while ARMED
//   done        high while state is DONE
// ---------------------------------------------------------------------------
module adc_capture_buf #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int POST_CNT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              arm,
  input  logic              trig,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] trig_ptr,
  output logic              wrapped,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]    post_cnt;
  logic [CNT_W-1:0]    post_next;

  logic wr_act;     // sample actually stored this cycle
  logic arm_act;    // arm accepted this cycle
  logic trig_act;   // trigger accepted this cycle
  logic counting;   // stored sample counts as a post-trigger sample
  logic post_full;  // this stored sample is the last post-trigger sample

  assign wr_act    = wr_en && ((state_q == S_ARMED) || (state_q == S_POST));
  assign arm_act   = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign trig_act  = trig && (state_q == S_ARMED);
  // The sample written in the trigger cycle itself is post sample 1.
  assign counting  = wr_act && ((state_q == S_POST) || trig_act);
  assign post_next = post_cnt + 1'b1;
  assign post_full = counting && (post_next == POST_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arm)       state_d = S_ARMED;
      S_ARMED: if (trig)      state_d = post_full ? S_DONE : S_POST;
      S_POST:  if (post_full) state_d = S_DONE;
      S_DONE:  if (arm)       state_d = S_ARMED;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    state = state_q;
    done  = (state_q == S_DONE);
  end

  // Pointers, post counter and capture status
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      post_cnt <= '0;
      trig_ptr <= '0;
      wrapped  <= 1'b0;
    end else if (arm_act) begin
      // trig_ptr deliberately survives a re-arm.
      wr_ptr   <= '0;
      post_cnt <= '0;
      wrapped  <= 1'b0;
    end else begin
      if (wr_act) begin
        wr_ptr <= wr_ptr + 1'b1;
        if ((state_q == S_ARMED) && (wr_ptr == '1)) wrapped <= 1'b1;
      end
      if (trig_act) trig_ptr <= wr_ptr;
      if (counting) post_cnt <= post_next;
    end
  end

  // Sample storage
  // NOTE: the memory array has no reset so it maps onto block RAM; its
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_act) mem[wr_ptr] <= din;
  end

  // Registered read port; a same-cycle write to the read address returns the
  // old contents because both sample the array before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_en;
      if (rd_en) dout <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_adc_capture_buf.sv
module tb_adc_capture_buf;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // ---- DUT a: DEPTH=16, POST_CNT=4 ----
  logic          rst = 1'b1, wr_en = 0, arm = 0, trig = 0, rd_en = 0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, wrapped, done;
  logic [1:0]    state;
  logic [AW-1:0] trig_ptr;

  adc_capture_buf #(.DATA_W(DW), .ADDR_W(AW), .POST_CNT(4)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .arm(arm), .trig(trig),
    .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout), .dout_valid(dout_valid),
    .state(state), .trig_ptr(trig_ptr), .wrapped(wrapped), .done(done)
  );

  // ---- DUT b: DEPTH=16, POST_CNT=DEPTH ----
  logic          rst_b = 1'b1, wr_en_b = 0, arm_b = 0, trig_b = 0, rd_en_b = 0;
  logic [DW-1:0] din_b = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] dout_b;
  logic          dout_valid_b, wrapped_b, done_b;
  logic [1:0]    state_b;
  logic [AW-1:0] trig_ptr_b;

  adc_capture_buf #(.DATA_W(DW), .ADDR_W(AW), .POST_CNT(16)) u_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .din(din_b), .arm(arm_b), .trig(trig_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .state(state_b), .trig_ptr(trig_ptr_b), .wrapped(wrapped_b), .done(done_b)
  );

  // ---- scoreboard for DUT a reads ----
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rd_exp_t;
  rd_exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid read beat must match the oldest outstanding request
  // in both data and arrival cycle.
  always @(negedge clk) begin
    if (!rst && dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_unexpected_valid", 32'(dout_valid), 32'(0));
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rd_data", 32'(dout), 32'(e.data));
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Advance one clock; strobes are single-cycle pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en = 0; arm = 0; trig = 0; rd_en = 0;
    wr_en_b = 0; arm_b = 0; trig_b = 0; rd_en_b = 0;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1; din = d;
    tick();
  endtask

  task automatic wr_b(input logic [DW-1:0] d);
    wr_en_b = 1; din_b = d;
    tick();
  endtask

  // Request a read on DUT a (issued with the next tick) and record the answer.
  task automatic req_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_exp_t e;
    rd_en = 1; rd_addr = a;
    e.data = exp;
    e.cyc  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic rd_b(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    rd_en_b = 1; rd_addr_b = a;
    tick();
    check(name, 32'(dout_b), 32'(exp));
    check({name, "_valid"}, 32'(dout_valid_b), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'(0));
    check("rst_trig_ptr", 32'(trig_ptr), 32'(0));
    check("rst_wrapped", 32'(wrapped), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_dout_valid", 32'(dout_valid), 32'(0));
    rst = 0; rst_b = 0;
    tick();

    // ---------------- ignored events in IDLE ----------------
    trig = 1; wr(16'h00AA);
    check("idle_ignore_state", 32'(state), 32'(0));
    check("idle_ignore_trig_ptr", 32'(trig_ptr), 32'(0));

    // ---------------- wrap in ARMED ----------------
    arm = 1; tick();
    check("arm_state", 32'(state), 32'(1));
    for (int i = 1; i <= 20; i++) begin
      wr(DW'(i));
      if (i == 15) check("wrap_not_yet", 32'(wrapped), 32'(0));
      if (i == 16) check("wrap_set", 32'(wrapped), 32'(1));
    end
    check("wrap_sticky", 32'(wrapped), 32'(1));
    check("wrap_state", 32'(state), 32'(1));
    trig = 1; tick();
    check("wrap_trig_state", 32'(state), 32'(2));
    check("wrap_trig_ptr_is_wr_ptr", 32'(trig_ptr), 32'(4));
    req_rd(4'd3, 16'd20); tick();
    // arm is ignored while POST
    wr(16'h0021);
    arm = 1; wr(16'h0022);
    check("post_arm_ignored_state", 32'(state), 32'(2));
    check("post_arm_ignored_wrapped", 32'(wrapped), 32'(1));
    wr(16'h0023);
    check("post_before_last", 32'(state), 32'(2));
    wr(16'h0024);
    check("post_done_state", 32'(state), 32'(3));
    check("post_done_flag", 32'(done), 32'(1));
    // writes and trig ignored in DONE
    trig = 1; wr(16'hBEEF);
    check("done_ignore_state", 32'(state), 32'(3));
    check("done_ignore_trig_ptr", 32'(trig_ptr), 32'(4));
    req_rd(4'd8, 16'd9);      tick();
    req_rd(4'd7, 16'h0024);   tick();
    req_rd(4'd4, 16'h0021);   tick();

    // ---------------- basic capture ----------------
    arm = 1; trig = 1; tick();  // arm wins over coincident trig
    check("arm_trig_state", 32'(state), 32'(1));
    check("arm_keeps_trig_ptr", 32'(trig_ptr), 32'(4));
    check("arm_clears_wrapped", 32'(wrapped), 32'(0));
    wr(16'h11); wr(16'h12); wr(16'h13);
    trig = 1; wr(16'h14);
    check("basic_post_state", 32'(state), 32'(2));
    check("basic_trig_ptr", 32'(trig_ptr), 32'(3));
    wr(16'h15); wr(16'h16);
    check("basic_still_post", 32'(state), 32'(2));
    check("basic_not_done", 32'(done), 32'(0));
    wr(16'h17);
    check("basic_done_state", 32'(state), 32'(3));
    check("basic_done_flag", 32'(done), 32'(1));
    check("basic_wrapped", 32'(wrapped), 32'(0));
    for (int a = 0; a < 7; a++) begin
      req_rd(AW'(a), DW'(16'h11 + a));
      tick();
    end

    // ---------------- read-during-write, then mid-POST reset ----------------
    arm = 1; tick();
    for (int i = 0; i < 5; i++) wr(DW'(16'h31 + i));
    req_rd(4'd5, 16'h16);  // old data while 0x36 is written to addr 5
    wr(16'h36);
    req_rd(4'd5, 16'h36); tick();
    trig = 1; wr(16'h37);
    check("rw_trig_ptr", 32'(trig_ptr), 32'(6));
    wr(16'h38);
    check("pre_rst_state", 32'(state), 32'(2));
    #2 rst = 1;
    #1;
    check("midrst_state", 32'(state), 32'(0));
    check("midrst_trig_ptr", 32'(trig_ptr), 32'(0));
    check("midrst_wrapped", 32'(wrapped), 32'(0));
    check("midrst_dout", 32'(dout), 32'(0));
    check("midrst_dout_valid", 32'(dout_valid), 32'(0));
    tick();
    rst = 0;
    tick();
    wr(16'hDEAD);
    check("post_rst_write_ignored_state", 32'(state), 32'(0));
    req_rd(4'd0, 16'h31); tick();   // read served in IDLE; addr 0 untouched
    tick();

    // ---------------- POST_CNT = DEPTH on DUT b ----------------
    arm_b = 1; tick();
    wr_b(16'h101); wr_b(16'h102); wr_b(16'h103);
    trig_b = 1; wr_b(16'h200);
    check("full_trig_ptr", 32'(trig_ptr_b), 32'(3));
    check("full_post_state", 32'(state_b), 32'(2));
    for (int k = 2; k <= 15; k++) wr_b(DW'(16'h200 + k - 1));
    check("full_before_last", 32'(state_b), 32'(2));
    wr_b(16'h20F);
    check("full_done_state", 32'(state_b), 32'(3));
    check("full_done_flag", 32'(done_b), 32'(1));
    check("full_wrapped_only_armed", 32'(wrapped_b), 32'(0));
    wr_b(16'hFFFF);
    rd_b(4'd2, 16'h20F, "full_last_sample");
    rd_b(4'd3, 16'h200, "full_first_post_kept");
    rd_b(4'd0, 16'h20D, "full_wrapped_sample");
    tick();
    check("full_valid_drops", 32'(dout_valid_b), 32'(0));
    check("full_dout_held", 32'(dout_b), 32'(16'h20D));

    repeat (3) tick();
    check("rd_pending", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
